// File: rtl/seq_detect_param.sv
// Programmable serial-bit sequence detector with masked compare and Moore match.
// Optional saturating hit counter (match_cnt) when SEQ_MATCH_CNT_EN is defined.
module seq_detect_param #(
  parameter int MAX_LEN = 5,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(5'b10111),
  parameter int DEF_LEN = 5,
  parameter int CNT_W = 16,
  localparam int LW = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               din_vld,
  input  logic               din,
  input  logic               overlap_en,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [MAX_LEN-1:0] cfg_mask,
  input  logic [LW-1:0]      cfg_len,
  output logic               cfg_err,
`ifdef SEQ_MATCH_CNT_EN
  output logic [CNT_W-1:0]   match_cnt,
`endif
  output logic               match
);

  if (DEF_LEN < 1 || DEF_LEN > MAX_LEN || CNT_W < 1) begin : g_bad_param
    $error("seq_detect_param: illegal parameter set");
  end

  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [MAX_LEN-1:0] mask_q, mask_d;
  logic [LW-1:0]      len_q, len_d;
  logic [LW-1:0]      fill_q, fill_d;
  logic               match_q, match_d;
  logic               cfg_err_q, cfg_err_d;

  logic               cfg_ok;
  logic               cfg_load;
  logic               smp;
  logic [MAX_LEN-1:0] hist_sh;
  logic [LW-1:0]      fill_inc;
  logic [MAX_LEN-1:0] len_mask;
  logic               hit;

  // Post-shift history/fill and masked pattern compare
  always_comb begin
    cfg_ok   = (cfg_len != '0) && (int'(cfg_len) <= MAX_LEN);
    cfg_load = !clr && cfg_we && cfg_ok;
    smp      = !clr && !cfg_load && din_vld;
    hist_sh  = MAX_LEN'({hist_q, din});
    fill_inc = (fill_q < len_q) ? fill_q + LW'(1) : len_q;
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
    hit = (fill_inc == len_q) &&
          (((hist_sh ^ pat_q) & mask_q & len_mask) == '0);
  end

  // Next state: clr beats cfg load beats sample
  always_comb begin
    hist_d    = hist_q;
    fill_d    = fill_q;
    pat_d     = pat_q;
    mask_d    = mask_q;
    len_d     = len_q;
    match_d   = 1'b0;
    cfg_err_d = cfg_we && !cfg_ok;
    if (clr) begin
      hist_d = '0;
      fill_d = '0;
    end else if (cfg_load) begin
      pat_d  = cfg_pattern;
      mask_d = cfg_mask;
      len_d  = cfg_len;
      hist_d = '0;
      fill_d = '0;
    end else if (smp) begin
      hist_d  = hist_sh;
      fill_d  = (hit && !overlap_en) ? '0 : fill_inc;
      match_d = hit;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q    <= '0;
      fill_q    <= '0;
      pat_q     <= DEF_PATTERN;
      mask_q    <= '1;
      len_q     <= LW'(DEF_LEN);
      match_q   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pat_q     <= pat_d;
      mask_q    <= mask_d;
      len_q     <= len_d;
      match_q   <= match_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign match   = match_q;
  assign cfg_err = cfg_err_q;

`ifdef SEQ_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating hit counter; survives cfg loads
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (smp && hit && cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed self-checking bench for seq_detect_param.
// Counter checks run only when SEQ_MATCH_CNT_EN is defined.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       din_vld;
  logic       din;
  logic       overlap_en;
  logic       cfg_we;
  logic [4:0] cfg_pattern;
  logic [4:0] cfg_mask;
  logic [2:0] cfg_len;
  logic       cfg_err;
  logic       match;
`ifdef SEQ_MATCH_CNT_EN
  logic [1:0] match_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_detect_param #(
    .MAX_LEN(5),
    .CNT_W  (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .din_vld    (din_vld),
    .din        (din),
    .overlap_en (overlap_en),
    .cfg_we     (cfg_we),
    .cfg_pattern(cfg_pattern),
    .cfg_mask   (cfg_mask),
    .cfg_len    (cfg_len),
    .cfg_err    (cfg_err),
`ifdef SEQ_MATCH_CNT_EN
    .match_cnt  (match_cnt),
`endif
    .match      (match)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic b,
                      input logic exp_m, input string tag);
    din_vld = v;
    din     = b;
    @(posedge clk);
    #1;
    din_vld = 1'b0;
    chk(tag, 32'(match), 32'(exp_m));
  endtask

  task automatic cfg(input logic [2:0] l, input logic [4:0] p,
                     input logic [4:0] m, input logic exp_err,
                     input string tag);
    cfg_we      = 1'b1;
    cfg_len     = l;
    cfg_pattern = p;
    cfg_mask    = m;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    chk({tag, "_err"}, 32'(cfg_err), 32'(exp_err));
    chk({tag, "_m"}, 32'(match), 32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    clr         = 1'b0;
    din_vld     = 1'b0;
    din         = 1'b0;
    overlap_en  = 1'b1;
    cfg_we      = 1'b0;
    cfg_pattern = '0;
    cfg_mask    = '0;
    cfg_len     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_err", 32'(cfg_err), 32'd0);
`ifdef SEQ_MATCH_CNT_EN
    chk("rst_cnt", 32'(match_cnt), 32'd0);
`endif
    rst_n = 1'b1;

    // default 10111
    step(1, 1, 0, "d0");
    step(1, 0, 0, "d1");
    step(1, 1, 0, "d2");
    step(1, 1, 0, "d3");
    step(1, 1, 1, "d4");
    step(0, 0, 0, "d_idle");

    // len3 101 overlapping
    overlap_en = 1'b1;
    cfg(3, 5'b00101, 5'b11111, 0, "cfg_ov");
    step(1, 1, 0, "ov0");
    step(1, 0, 0, "ov1");
    step(1, 1, 1, "ov2");
    step(1, 0, 0, "ov3");
    step(1, 1, 1, "ov4");

    // len3 101 non-overlapping
    overlap_en = 1'b0;
    cfg(3, 5'b00101, 5'b11111, 0, "cfg_no");
    step(1, 1, 0, "no0");
    step(1, 0, 0, "no1");
    step(1, 1, 1, "no2");
    step(1, 0, 0, "no3");
    step(1, 1, 0, "no4");

    // mask 101: middle bit don't care
    overlap_en = 1'b1;
    cfg(3, 5'b00101, 5'b00101, 0, "cfg_mk");
    step(1, 1, 0, "mk0");
    step(1, 1, 0, "mk1");
    step(1, 1, 1, "mk2");
    cfg(3, 5'b00101, 5'b00101, 0, "cfg_mk2");
    step(1, 0, 0, "mk3");
    step(1, 1, 0, "mk4");
    step(1, 1, 0, "mk5");

    // back to 10111, valid gaps
    cfg(5, 5'b10111, 5'b11111, 0, "cfg_def");
    step(1, 1, 0, "g0");
    step(0, 0, 0, "g1");
    step(1, 0, 0, "g2");
    step(0, 1, 0, "g3");
    step(0, 1, 0, "g4");
    step(1, 1, 0, "g5");
    step(1, 1, 0, "g6");
    step(0, 0, 0, "g7");
    step(1, 1, 1, "g8");
    step(0, 0, 0, "g9");

    // illegal lengths leave config intact
    cfg(0, 5'b00000, 5'b00000, 1, "bad0");
    step(0, 0, 0, "bad0_clr");
    chk("bad0_pulse", 32'(cfg_err), 32'd0);
    cfg(6, 5'b00000, 5'b00000, 1, "bad6");
    step(1, 1, 0, "e0");
    step(1, 0, 0, "e1");
    step(1, 1, 0, "e2");
    step(1, 1, 0, "e3");
    step(1, 1, 1, "e4");

    // clr on completing bit
    step(1, 1, 0, "c0");
    step(1, 0, 0, "c1");
    step(1, 1, 0, "c2");
    step(1, 1, 0, "c3");
    clr = 1'b1;
    step(1, 1, 0, "c4_clr");
    clr = 1'b0;
    step(1, 1, 0, "c5");
    step(1, 0, 0, "c6");
    step(1, 1, 0, "c7");
    step(1, 1, 0, "c8");
    step(1, 1, 1, "c9");

    // legal cfg load drops a concurrent sample
    din_vld = 1'b1;
    din     = 1'b1;
    cfg(1, 5'b00001, 5'b11111, 0, "cfg_drop");
    step(1, 1, 1, "drop1");
    cfg(5, 5'b10111, 5'b11111, 0, "cfg_def2");

    // reset mid-sequence
    step(1, 1, 0, "r0");
    step(1, 0, 0, "r1");
    step(1, 1, 0, "r2");
    step(1, 1, 0, "r3");
    rst_n = 1'b0;
    #2;
    chk("r_async", 32'(match), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1, 1, 0, "r4");

`ifdef SEQ_MATCH_CNT_EN
    clr = 1'b1;
    step(0, 0, 0, "k_clr");
    clr = 1'b0;
    chk("k_zero", 32'(match_cnt), 32'd0);
    overlap_en = 1'b1;
    cfg(1, 5'b00001, 5'b11111, 0, "cfg_k");
    step(1, 1, 1, "k0");
    chk("k_one", 32'(match_cnt), 32'd1);
    step(1, 1, 1, "k1");
    step(1, 1, 1, "k2");
    step(1, 1, 1, "k3");
    step(1, 1, 1, "k4");
    chk("k_sat", 32'(match_cnt), 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
